// File: rtl/flag_catcher_pkg.sv
// Shared types and helpers for the shooting-flag LED receiver.
// Holds the FSM encoding, the known frame prefix and the symbol de-rotation.
package flag_catcher_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } fsm_state_t;

  localparam int FLAG_LEN_DEF   = 45;
  localparam int PREFIX_LEN_DEF = 5;
  localparam int IDX_W          = $clog2(FLAG_LEN_DEF);

  // "grey{" -- the fixed leading bytes every frame starts with.
  localparam logic [7:0] PREFIX [PREFIX_LEN_DEF] = '{8'd103, 8'd114, 8'd101, 8'd121, 8'd123};
  localparam logic [7:0] LEAD_BYTE = 8'd103;

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] k);
    logic [15:0] dbl;
    dbl = {x, x} >> k;
    return dbl[7:0];
  endfunction

  // Out-of-range indices return 0 so callers never index past the table.
  function automatic logic [7:0] prefix_byte(input logic [IDX_W-1:0] i);
    logic [7:0] b;
    b = 8'h00;
    for (int j = 0; j < PREFIX_LEN_DEF; j++) begin
      if (i == IDX_W'(j)) b = PREFIX[j];
    end
    return b;
  endfunction

endpackage

// File: rtl/flag_catcher_sym.sv
// Symbol sampler: synchronizes the LED bus and strobes once per symbol at
// mid-symbol, re-centering its phase on every observed bus change.
module flag_sym_sampler #(
  parameter int SYM_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cats,
  output logic [7:0] sym,
  output logic       sym_stb
);

  localparam int CNT_W = $clog2(SYM_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD_FULL = CNT_W'(SYM_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELOAD_HALF = CNT_W'(SYM_CYCLES / 2);

  logic [7:0]       sync_p0;
  logic [7:0]       sync_p1;
  logic [7:0]       prev_p2;
  logic [CNT_W-1:0] phase;
  logic             changed;

  assign changed = (sync_p1 != prev_p2);
  assign sym     = sync_p1;
  // A change on the same cycle the counter expires wins: realign instead of sampling.
  assign sym_stb = (phase == '0) && !changed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
      phase   <= RELOAD_FULL;
    end else begin
      // stage p0 -> p1 -> p2: two-flop synchronizer plus one-cycle history
      sync_p0 <= cats;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      if (changed) begin
        phase <= RELOAD_HALF;
      end else if (phase == '0) begin
        phase <= RELOAD_FULL;
      end else begin
        phase <= phase - 1'b1;
      end
    end
  end

endmodule

// File: rtl/flag_catcher.sv
// Shooting-flag receiver: aligns to the "grey{" prefix, de-rotates each
// symbol and streams recovered bytes over a valid/ready output.
module flag_catcher
  import flag_catcher_pkg::*;
#(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int SYM_CYCLES = 2 * (CLK_FREQ / 30 + 1),
  parameter int FLAG_LEN   = 45,
  parameter int PREFIX_LEN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cats,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             frame_done,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] PFX_END  = IDX_W'(PREFIX_LEN);
  localparam logic [IDX_W-1:0] PFX_LAST = IDX_W'(PREFIX_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FLAG_LEN - 1);

  logic [7:0]       sym;
  logic             sym_stb;

  fsm_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             locked_nxt;

  logic [7:0]       rot;
  logic             prefix_ok;
  logic             emit;
  logic             emit_last;

  flag_sym_sampler #(
    .SYM_CYCLES(SYM_CYCLES)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .cats   (cats),
    .sym    (sym),
    .sym_stb(sym_stb)
  );

  assign rot       = rotr8(sym, idx[2:0]);
  assign prefix_ok = (rot == prefix_byte(idx));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HUNT;
      idx    <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      locked <= locked_nxt;
    end
  end

  // Next-state logic; everything advances only on a sample strobe
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    locked_nxt = locked;
    if (sym_stb) begin
      case (state)
        HUNT: begin
          if (sym == LEAD_BYTE) begin
            state_nxt = CHECK;
            idx_nxt   = IDX_W'(1);
          end
        end
        CHECK: begin
          if (prefix_ok) begin
            if (idx == PFX_LAST) begin
              state_nxt  = LOCK;
              idx_nxt    = PFX_END;
              locked_nxt = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else if (sym == LEAD_BYTE) begin
            idx_nxt = IDX_W'(1);
          end else begin
            state_nxt = HUNT;
            idx_nxt   = '0;
          end
        end
        LOCK: begin
          // Inside LOCK the prefix of every new frame is re-verified.
          if (idx < PFX_END) begin
            if (prefix_ok) begin
              idx_nxt = idx + 1'b1;
            end else begin
              state_nxt  = HUNT;
              idx_nxt    = '0;
              locked_nxt = 1'b0;
            end
          end else begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end
        default: begin
          state_nxt  = HUNT;
          idx_nxt    = '0;
          locked_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output decode: which strobes produce a payload byte
  always_comb begin
    emit      = 1'b0;
    emit_last = 1'b0;
    if (sym_stb && (state == LOCK) && (idx >= PFX_END)) begin
      emit      = 1'b1;
      emit_last = (idx == IDX_LAST);
    end
  end

  // Output register with valid/ready hold and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_idx    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (emit) begin
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_data   <= rot;
          out_idx    <= idx;
          out_valid  <= 1'b1;
          frame_done <= emit_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_flag_catcher.sv
// Directed bench for flag_catcher with a short symbol period.
module tb_flag_catcher;

  localparam int SYM = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cats;
  logic [7:0] out_data;
  logic [5:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       locked;
  logic       frame_done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [13:0] acc_q[$];
  int          fd_count = 0;
  logic [7:0]  fd_data = 8'h00;

  string FLAG = "grey{eh_live_firing_dont_turn_your_brain_off}";

  always #5 clk = ~clk;

  flag_catcher #(.SYM_CYCLES(SYM)) dut (
    .clk       (clk),
    .rst       (rst),
    .cats      (cats),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  // Record accepted bytes and frame_done pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) acc_q.push_back({out_idx, out_data});
      if (frame_done) begin
        fd_count = fd_count + 1;
        fd_data  = out_data;
      end
    end
  end

  initial begin
    #300_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] d;
    d = {x, x} << (k % 8);
    return d[15:8];
  endfunction

  function automatic logic [7:0] flag_at(input int n);
    return FLAG[n];
  endfunction

  function automatic logic [7:0] sym_at(input int n);
    return rotl8(flag_at(n), n % 8);
  endfunction

  task automatic send(input logic [7:0] v);
    cats = v;
    repeat (SYM) @(posedge clk);
    #1;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) send(sym_at(n));
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    cats = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cats = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (out_idx !== 6'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    rst = 1'b0;
  endtask

  task automatic test_clean_lock();
    int base;
    out_ready = 1'b1;
    base = acc_q.size();
    send(8'd103); send(8'd228); send(8'd149); send(8'd203);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", locked); end
    send(8'd183);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_prefix got %b want 1", locked); end
    checks++; if (acc_q.size() != base) begin errors++; $display("FAIL prefix_not_emitted got %0d bytes want 0", acc_q.size() - base); end
    send(8'd172);
    checks++; if (acc_q.size() != base + 1) begin errors++; $display("FAIL first_byte_count got %0d want 1", acc_q.size() - base); end
    else begin
      checks++; if (acc_q[base] !== {6'd5, 8'd101}) begin errors++; $display("FAIL first_byte got idx %0d data %0d want idx 5 data 101", acc_q[base][13:8], acc_q[base][7:0]); end
    end
  endtask

  task automatic test_full_frame();
    int base, fdb, n0;
    base = acc_q.size() - 1;
    fdb  = fd_count;
    send_range(6, 44);
    checks++; if (acc_q.size() != base + 40) begin errors++; $display("FAIL frame1_count got %0d want 40", acc_q.size() - base); end
    else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (acc_q[base + i] !== {6'(i + 5), flag_at(i + 5)}) begin
          errors++; $display("FAIL frame1_byte%0d got %h want %h", i + 5, acc_q[base + i], {6'(i + 5), flag_at(i + 5)});
        end
      end
    end
    checks++; if (fd_count != fdb + 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fd_count - fdb); end
    checks++; if (fd_data !== 8'd125) begin errors++; $display("FAIL frame_done_data got %0d want 125", fd_data); end
    for (int n = 0; n < 5; n++) begin
      send(sym_at(n));
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL frame2_prefix%0d_locked got %b want 1", n, locked); end
    end
    n0 = acc_q.size();
    send_range(5, 44);
    checks++; if (acc_q.size() != n0 + 40) begin errors++; $display("FAIL frame2_count got %0d want 40", acc_q.size() - n0); end
    checks++; if (acc_q[acc_q.size() - 1] !== {6'd44, 8'd125}) begin errors++; $display("FAIL frame2_last got %h want %h", acc_q[acc_q.size() - 1], {6'd44, 8'd125}); end
    checks++; if (fd_count != fdb + 2) begin errors++; $display("FAIL frame2_done_count got %0d want 2", fd_count - fdb); end
  endtask

  task automatic test_backpressure();
    int base;
    send_range(0, 4);
    out_ready = 1'b0;
    base = acc_q.size();
    send(sym_at(5));
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_no_overrun_yet got %b want 0", overrun); end
    send(sym_at(6));
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", overrun); end
    checks++; if (out_data !== 8'd101) begin errors++; $display("FAIL bp_held_data got %0d want 101", out_data); end
    checks++; if (out_idx !== 6'd5) begin errors++; $display("FAIL bp_held_idx got %0d want 5", out_idx); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", out_valid); end
    checks++; if (acc_q.size() != base + 1) begin errors++; $display("FAIL bp_accept_count got %0d want 1", acc_q.size() - base); end
    else begin
      checks++; if (acc_q[base] !== {6'd5, 8'd101}) begin errors++; $display("FAIL bp_accepted got %h want %h", acc_q[base], {6'd5, 8'd101}); end
    end
    send_range(7, 44);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_false_start();
    do_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fs_overrun_cleared got %b want 0", overrun); end
    send(8'd103); send(8'd103); send(8'd228); send(8'd149); send(8'd203);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL fs_early_lock got %b want 0", locked); end
    send(8'd183);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL fs_relock got %b want 1", locked); end
    do_reset();
    send(8'd103); send(8'h55);
    send(8'd228); send(8'd149); send(8'd203); send(8'd183);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL fs_abort_locked got %b want 0", locked); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fs_abort_valid got %b want 0", out_valid); end
  endtask

  task automatic test_lock_loss();
    int base;
    do_reset();
    out_ready = 1'b1;
    send_range(0, 44);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ll_frame1_locked got %b want 1", locked); end
    base = acc_q.size();
    send(8'h00);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ll_dropped got %b want 0", locked); end
    checks++; if (acc_q.size() != base || out_valid !== 1'b0) begin errors++; $display("FAIL ll_no_emit got %0d bytes valid %b want 0 bytes valid 0", acc_q.size() - base, out_valid); end
    send_range(1, 44);
    send_range(0, 4);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ll_relock got %b want 1", locked); end
    send(sym_at(5));
    checks++; if (acc_q.size() != base + 1) begin errors++; $display("FAIL ll_relock_count got %0d want 1", acc_q.size() - base); end
    checks++; if (acc_q[acc_q.size() - 1] !== {6'd5, 8'd101}) begin errors++; $display("FAIL ll_relock_byte got %h want %h", acc_q[acc_q.size() - 1], {6'd5, 8'd101}); end
  endtask

  task automatic test_walking_and_reset();
    do_reset();
    for (int k = 0; k < 100; k++) begin
      send(rotl8(8'h05, k));
      checks++;
      if (locked !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL walk%0d got locked %b valid %b want 0 0", k, locked, out_valid);
      end
    end
    send_range(0, 4);
    out_ready = 1'b0;
    send(sym_at(5));
    send(sym_at(6));
    checks++; if (locked !== 1'b1 || out_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL pre_rst got locked %b valid %b overrun %b want 1 1 1", locked, out_valid, overrun);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
    checks++; if (out_idx !== 6'd0) begin errors++; $display("FAIL rst_out_idx got %0d want 0", out_idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b want 0", locked); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", overrun); end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cats = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_clean_lock();
    test_full_frame();
    test_backpressure();
    test_false_start();
    test_lock_loss();
    test_walking_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
